// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: ALU codes, ACC source selects,
// controller opcodes and instruction field positions.
package cpu_pkg;

  localparam int OPC_W   = 4;
  localparam int ALU_W   = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [ALU_W-1:0] {
    ALU_PASS = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_NOR  = 4'b0011,
    ALU_SHL  = 4'b1011,
    ALU_SHR  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ACC_ALU  = 2'b00,
    ACC_REG  = 2'b01,
    ACC_IMM  = 2'b10,
    ACC_HOLD = 2'b11
  } acc_sel_e;

  // Opcode map decoded by the controller; the datapath only reports the field.
  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h5;
  localparam logic [OPC_W-1:0] OP_STR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMPR = 4'h8;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC   = 4'hA;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'hB;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hC;

  // Opcode occupies the top OPC_W bits, directly above the immediate.
  function automatic int opc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int opc_msb(input int data_w);
    return data_w + OPC_W - 1;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the accumulator datapath.
// CPU_DATAPATH_SHIFT_CARRY_EN: shifts report the bit shifted out as carry.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ALU_W-1:0]  sel_i,
  output logic [DATA_W-1:0] res_o,
  output logic              cout_o
);

  always_comb begin
    res_o  = a_i;
    cout_o = 1'b0;
    case (sel_i)
      ALU_ADD: {cout_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: begin
        res_o  = a_i - b_i;
        cout_o = (a_i < b_i);
      end
      ALU_NOR: res_o = ~(a_i | b_i);
      ALU_SHR: begin
        res_o = {1'b0, a_i[DATA_W-1:1]};
`ifdef CPU_DATAPATH_SHIFT_CARRY_EN
        cout_o = a_i[0];
`else
        cout_o = 1'b0;
`endif
      end
      ALU_SHL: begin
        res_o = {a_i[DATA_W-2:0], 1'b0};
`ifdef CPU_DATAPATH_SHIFT_CARRY_EN
        cout_o = a_i[DATA_W-1];
`else
        cout_o = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator-machine datapath: PC, IR, ACC, carry, register file and ALU.
// CPU_DATAPATH_SHIFT_CARRY_EN (in cpu_alu) makes shifts update C.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic                    CLK,
  input  logic                    CLB,
  input  logic [DATA_W+OPC_W-1:0] InstrIn,
  input  logic                    LoadIR,
  input  logic                    IncPC,
  input  logic                    SelPC,
  input  logic                    LoadPC,
  input  logic                    LoadReg,
  input  logic                    LoadAcc,
  input  logic [1:0]              SelAcc,
  input  logic [ALU_W-1:0]        SelALU,
  output logic [OPC_W-1:0]        Opcode,
  output logic                    Z,
  output logic                    C,
  output logic [ADDR_W-1:0]       PCOut,
  output logic [DATA_W-1:0]       AccOut
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [ADDR_W-1:0]       pc_q, pc_d, pc_tgt;
  logic [DATA_W+OPC_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]       acc_q, acc_d;
  logic                    c_q, c_d;
  logic [DATA_W-1:0]       reg_q [NREG];

  logic [DATA_W-1:0] imm, rb, pc_src, alu_res;
  logic [IDX_W-1:0]  idx;
  logic              alu_cout;

  assign imm = ir_q[IMM_LSB +: DATA_W];
  assign idx = imm[IDX_W-1:0];
  assign rb  = reg_q[idx];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i    (acc_q),
    .b_i    (rb),
    .sel_i  (SelALU),
    .res_o  (alu_res),
    .cout_o (alu_cout)
  );

  // Jump targets come from DATA_W-wide sources; fit them to the PC width.
  assign pc_src = SelPC ? imm : rb;
  if (ADDR_W > DATA_W) begin : g_pc_zext
    assign pc_tgt = {{(ADDR_W-DATA_W){1'b0}}, pc_src};
  end else begin : g_pc_trunc
    assign pc_tgt = pc_src[ADDR_W-1:0];
  end

  always_comb begin
    pc_d = pc_q;
    if (LoadPC)     pc_d = pc_tgt;
    else if (IncPC) pc_d = pc_q + ADDR_W'(1);
  end

  assign ir_d = LoadIR ? InstrIn : ir_q;

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    if (LoadAcc) begin
      case (SelAcc)
        ACC_ALU: begin
          acc_d = alu_res;
          c_d   = alu_cout;
        end
        ACC_REG: acc_d = rb;
        ACC_IMM: acc_d = imm;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      c_q   <= c_d;
    end
  end

  // Every read above sees pre-edge state, so a same-edge store gets the old ACC.
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
    end else if (LoadReg) begin
      reg_q[idx] <= acc_q;
    end
  end

  assign Opcode = ir_q[opc_msb(DATA_W):opc_lsb(DATA_W)];
  assign Z      = (acc_q == '0);
  assign C      = c_q;
  assign PCOut  = pc_q;
  assign AccOut = acc_q;

endmodule
